// File: rtl/dlx_pipe_if.sv
// dlx_pipe_if: DLX fetch stage, owns the PC and feeds the IF/ID register from a single-outstanding imem port.
module dlx_pipe_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = {6'h00, 20'b0, 6'h00}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        dc_wait,
  input  logic        id_cond,
  input  logic [31:0] id_npc,
  input  logic        id_halt,
  input  logic        id_illegal_instr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_npc,
  output logic [31:0] if_id_ir,
  output logic        if_halted
);
  typedef enum logic [1:0] {START, WAIT, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, imem_addr_q, imem_addr_d, if_id_ir_q, if_id_ir_d;
  logic [31:0] if_id_npc_q, if_id_npc_d, buf_ir_q, buf_ir_d;
  logic imem_req_q, imem_req_d, if_halted_q, if_halted_d, buf_v_q, buf_v_d, drop_q, drop_d;
  logic advance, got, data_ok, pend;
  always_comb begin
    advance = ~stall & ~dc_wait & (state_q != HALT);
    got = imem_req_q & imem_valid;
    data_ok = got & ~drop_q;
    pend = imem_req_q & ~imem_valid;
    state_d = state_q;
    pc_d = pc_q;
    imem_req_d = got ? 1'b0 : imem_req_q;
    imem_addr_d = imem_addr_q;
    if_id_ir_d = if_id_ir_q;
    if_id_npc_d = if_id_npc_q;
    if_halted_d = if_halted_q;
    buf_ir_d = buf_ir_q;
    buf_v_d = buf_v_q;
    drop_d = (got & drop_q) ? 1'b0 : drop_q;
    // Handshake bookkeeping runs even while frozen so a response is never lost.
    if (got & drop_q & (state_q == WAIT)) state_d = START;
    if (data_ok & ~advance & (state_q == WAIT)) begin
      buf_ir_d = imem_rdata;
      buf_v_d = 1'b1;
    end
    if (advance) begin
      if (id_halt | id_illegal_instr) begin
        if_id_ir_d = NOP_WORD;
        if_halted_d = 1'b1;
        buf_v_d = 1'b0;
        state_d = HALT;
      end else if (id_cond) begin
        pc_d = id_npc;
        if_id_ir_d = NOP_WORD;
        if_id_npc_d = id_npc;
        buf_v_d = 1'b0;
        drop_d = pend | drop_d;
        state_d = pend ? WAIT : START;
      end else if (state_q == START) begin
        imem_req_d = 1'b1;
        imem_addr_d = pc_q;
        state_d = WAIT;
      end else if (buf_v_q | data_ok) begin
        if_id_ir_d = buf_v_q ? buf_ir_q : imem_rdata;
        if_id_npc_d = pc_q + 32'd4;
        pc_d = pc_q + 32'd4;
        buf_v_d = 1'b0;
        state_d = START;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= START;
      pc_q <= RESET_PC;
      imem_req_q <= 1'b0;
      imem_addr_q <= RESET_PC;
      if_id_ir_q <= NOP_WORD;
      if_id_npc_q <= RESET_PC;
      if_halted_q <= 1'b0;
      buf_ir_q <= '0;
      buf_v_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      imem_req_q <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_id_ir_q <= if_id_ir_d;
      if_id_npc_q <= if_id_npc_d;
      if_halted_q <= if_halted_d;
      buf_ir_q <= buf_ir_d;
      buf_v_q <= buf_v_d;
      drop_q <= drop_d;
    end
  end
  assign imem_req = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_id_ir = if_id_ir_q;
  assign if_id_npc = if_id_npc_q;
  assign if_halted = if_halted_q;
endmodule

// File: tb/tb_dlx_pipe_if.sv
// tb_dlx_pipe_if: random front-end traffic against a program-order model of the fetch stream.
module tb_dlx_pipe_if;
  localparam logic [31:0] NOP = {6'h15, 20'b0, 6'h00};
  logic clk = 1'b0;
  logic rst, stall, dc_wait, id_cond, id_halt, id_illegal_instr, imem_valid, imem_req, if_halted;
  logic [31:0] id_npc, imem_addr, imem_rdata, if_id_npc, if_id_ir;
  logic [31:0] exp_pc, req_addr;
  bit halted, req_seen;
  int lat, max_lat, idle, n_instr, total, bad;
  always #5 clk = ~clk;
  dlx_pipe_if #(.RESET_PC(32'h0), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .dc_wait(dc_wait), .id_cond(id_cond), .id_npc(id_npc),
    .id_halt(id_halt), .id_illegal_instr(id_illegal_instr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .if_id_npc(if_id_npc), .if_id_ir(if_id_ir), .if_halted(if_halted)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  // One clock: drive inputs and the memory response, then judge the outputs against the fetch model.
  task automatic cyc(input logic s, input logic dw, input logic c, input logic h, input logic il,
                     input logic [31:0] tgt);
    logic [31:0] pir, pnpc;
    logic adv;
    stall = s; dc_wait = dw; id_cond = c; id_npc = tgt; id_halt = h; id_illegal_instr = il;
    if (halted) check("halt_noreq", {31'b0, imem_req & ~req_seen}, 32'd0);
    if (imem_req && !req_seen) begin
      check("req_addr", imem_addr, exp_pc);
      req_seen = 1;
      req_addr = imem_addr;
      lat = $urandom_range(0, max_lat);
    end else if (req_seen) check("addr_stable", imem_addr, req_addr);
    imem_valid = req_seen && lat == 0;
    imem_rdata = imem_valid ? (req_addr | 32'h1) : 32'h0;
    if (req_seen) begin
      if (lat == 0) req_seen = 0;
      else lat--;
    end
    pir = if_id_ir; pnpc = if_id_npc;
    adv = !s && !dw && !halted;
    @(posedge clk);
    @(negedge clk);
    imem_valid = 1'b0;
    if (!adv) begin
      check("hold_ir", if_id_ir, pir);
      check("hold_npc", if_id_npc, pnpc);
    end else if (h || il) begin
      check("halt_ir", if_id_ir, NOP);
      halted = 1;
    end else if (c) begin
      check("squash_ir", if_id_ir, NOP);
      check("squash_npc", if_id_npc, tgt);
      exp_pc = tgt;
      idle = 0;
    end else if (if_id_ir !== pir) begin
      check("ir", if_id_ir, exp_pc | 32'h1);
      check("npc", if_id_npc, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      idle = 0;
      n_instr++;
    end else begin
      idle++;
      if (idle == 30) check("progress", idle, 0);
    end
    check("halted", {31'b0, if_halted}, {31'b0, halted});
    if (halted) check("halt_nop", if_id_ir, NOP);
  endtask
  task automatic rcyc();
    logic [31:0] t;
    t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
    cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 0, 0, t);
  endtask
  task automatic arst();
    #2 rst = 1'b0;
    imem_valid = 1'b0;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ir", if_id_ir, NOP);
    check("rst_npc", if_id_npc, 32'h0);
    check("rst_halted", {31'b0, if_halted}, 32'd0);
    halted = 0; exp_pc = 0; req_seen = 0; idle = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    int n0;
    rst = 1'b0; stall = 0; dc_wait = 0; id_cond = 0; id_npc = 0; id_halt = 0; id_illegal_instr = 0;
    imem_valid = 0; imem_rdata = 0;
    exp_pc = 0; req_addr = 0; halted = 0; req_seen = 0; lat = 0; max_lat = 0;
    idle = 0; n_instr = 0; total = 0; bad = 0;
    #12;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_ir", if_id_ir, NOP);
    check("rst_npc", if_id_npc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) cyc(0, 0, 0, 0, 0, 0);
    check("thruput", {31'b0, n_instr >= 3}, 32'd1);
    cyc(0, 0, 1, 0, 0, 32'h100);
    repeat (6) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && !imem_req; i++) cyc(0, 0, 0, 0, 0, 0);
    n0 = n_instr;
    repeat (3) begin
      cyc(1, 0, 0, 0, 0, 0);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("unstall_ir", n_instr, n0 + 1);
    max_lat = 2;
    repeat (800) rcyc();
    cyc(0, 0, 0, 1, 0, 0);
    repeat (20) rcyc();
    arst();
    repeat (5) rcyc();
    for (int i = 0; i < 20 && !imem_req; i++) cyc(0, 0, 0, 0, 0, 0);
    check("wait_req", {31'b0, imem_req}, 32'd1);
    arst();
    repeat (30) rcyc();
    cyc(0, 0, 0, 0, 1, 0);
    repeat (20) rcyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
